simt_div_ctrl: RTL and testbench

Divergence controller that sequences the per-core predicate/mask stack in the SIMT scheduler. It accepts structured-branch ops (IF/ELSE/ENDIF) from decode, together with a per-core condition vector. It drives the stack's push/pop/comp/d controls and publishes the active core mask to issue. It also tracks nesting depth and flags overflow and underflow.

---
 rtl/simt_div_ctrl.sv | 133 +++++++++++++
 tb/tb_simt_div_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/simt_div_ctrl.sv
// simt_div_ctrl: divergence controller for the SIMT per-core mask stack.
// Sequences IF/ELSE/ENDIF into push/pop strobes on an external mask stack,
// publishes the active lane mask, and tracks nesting depth with sticky
// overflow/underflow flags.
module simt_div_ctrl #(
  parameter int unsigned N_CORES     = 4,
  parameter int unsigned STACK_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CORES-1:0]     core_en,
  input  logic                   op_valid,
  input  logic [1:0]             op,
  input  logic [N_CORES-1:0]     cond,
  output logic                   op_ready,
  output logic [N_CORES-1:0]     active_mask,
  output logic                   mask_valid,
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   none_taken,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic [N_CORES-1:0]     ps_d,
  output logic                   ps_push,
  output logic                   ps_pop,
  output logic                   ps_comp,
  input  logic [N_CORES-1:0]     ps_q
);

  typedef enum logic [1:0] {
    S_INIT      = 2'b00,
    S_IDLE      = 2'b01,
    S_ELSE_PUSH = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_IF    = 2'b01,
    OP_ELSE  = 2'b10,
    OP_ENDIF = 2'b11
  } op_t;

  // Stack pointer 0 is a zero guard and 1 holds the root mask, so the deepest
  // usable nesting level is two below the pointer range.
  localparam logic [STACK_DEPTH-1:0] DEPTH_LIMIT = STACK_DEPTH'((1 << STACK_DEPTH) - 2);

  state_t               state, state_nxt;
  op_t                  op_dec;
  logic [N_CORES-1:0]   t_mask;
  logic                 accept;
  logic                 if_ok, if_ovf, else_ok, endif_ok, pop_unf;

  assign op_dec      = op_t'(op);
  assign active_mask = ps_q;
  assign ps_comp     = 1'b0;

  // Op decode with overflow/underflow qualification.
  always_comb begin
    accept   = op_valid && op_ready;
    if_ok    = accept && (op_dec == OP_IF) && (depth != DEPTH_LIMIT);
    if_ovf   = accept && (op_dec == OP_IF) && (depth == DEPTH_LIMIT);
    else_ok  = accept && (op_dec == OP_ELSE) && (depth != '0);
    endif_ok = accept && (op_dec == OP_ENDIF) && (depth != '0);
    pop_unf  = accept && ((op_dec == OP_ELSE) || (op_dec == OP_ENDIF)) && (depth == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:      state_nxt = S_IDLE;
      S_IDLE:      state_nxt = else_ok ? S_ELSE_PUSH : S_IDLE;
      S_ELSE_PUSH: state_nxt = S_IDLE;
      default:     state_nxt = S_INIT;
    endcase
  end

  // Output logic; strobes are held low while reset is asserted.
  always_comb begin
    op_ready   = 1'b0;
    mask_valid = 1'b0;
    ps_push    = 1'b0;
    ps_pop     = 1'b0;
    ps_d       = '0;
    if (!reset) begin
      case (state)
        S_INIT: begin
          ps_push = 1'b1;
          ps_d    = core_en;
        end
        S_IDLE: begin
          op_ready   = 1'b1;
          mask_valid = 1'b1;
          if (if_ok) begin
            ps_push = 1'b1;
            ps_d    = ps_q & cond;
          end
          if (else_ok || endif_ok) ps_pop = 1'b1;
        end
        S_ELSE_PUSH: begin
          // ps_q now shows the parent mask after the pop.
          ps_push = 1'b1;
          ps_d    = ps_q & ~t_mask;
        end
        default: ;
      endcase
    end
  end

  // Depth, taken-mask latch, skip hint and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth         <= '0;
      t_mask        <= '0;
      none_taken    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (if_ok)    depth <= depth + STACK_DEPTH'(1);
      if (endif_ok) depth <= depth - STACK_DEPTH'(1);
      if (else_ok)  t_mask <= ps_q;
      if (if_ovf)   err_overflow <= 1'b1;
      if (pop_unf)  err_underflow <= 1'b1;
      none_taken <= if_ok && ((ps_q & cond) == '0);
    end
  end

endmodule

// File: tb/tb_simt_div_ctrl.sv
// tb_simt_div_ctrl: directed plus random stimulus against a queue-based
// reference of the lane-mask stack; includes a behavioural mask stack.
module tb_simt_div_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned SD = 3;
  localparam logic [1:0] NOP = 2'b00, IF = 2'b01, ELS = 2'b10, ENDIF = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  core_en;
  logic          op_valid;
  logic [1:0]    op;
  logic [N-1:0]  cond;
  logic          op_ready, mask_valid, none_taken, err_overflow, err_underflow;
  logic [N-1:0]  active_mask, ps_d, ps_q;
  logic [SD-1:0] depth;
  logic          ps_push, ps_pop, ps_comp;

  int total = 0;
  int bad   = 0;

  // Reference state: queue of masks, back = current mask.
  logic [N-1:0] ms[$];
  bit m_ovf, m_unf, m_nt;

  simt_div_ctrl #(.N_CORES(N), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .core_en(core_en), .op_valid(op_valid), .op(op),
    .cond(cond), .op_ready(op_ready), .active_mask(active_mask),
    .mask_valid(mask_valid), .depth(depth), .none_taken(none_taken),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .ps_d(ps_d),
    .ps_push(ps_push), .ps_pop(ps_pop), .ps_comp(ps_comp), .ps_q(ps_q)
  );

  always #5 clk = ~clk;

  // Behavioural mask stack (environment, not the reference).
  logic [N-1:0]  stk [0:7];
  logic [SD-1:0] sp;
  logic [SD-1:0] sp_n;
  assign sp_n = sp + 3'd1;
  assign ps_q = stk[sp];
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < 8; i++) stk[i] <= '0;
    end else if (ps_push) begin
      sp <= sp_n;
      stk[sp_n] <= ps_d;
    end else if (ps_pop) begin
      sp <= sp - 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".op_ready"}, 32'(op_ready), 32'd1);
    chk({tag, ".mask_valid"}, 32'(mask_valid), 32'd1);
    chk({tag, ".mask"}, 32'(active_mask), 32'(ms[$]));
    chk({tag, ".depth"}, 32'(depth), 32'(ms.size() - 1));
    chk({tag, ".ovf"}, 32'(err_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(err_underflow), 32'(m_unf));
    chk({tag, ".none_taken"}, 32'(none_taken), 32'(m_nt));
    chk({tag, ".comp"}, 32'(ps_comp), 32'd0);
  endtask

  task automatic do_reset(input logic [N-1:0] ce, input string tag);
    reset = 1'b1; core_en = ce; op_valid = 1'b0; op = NOP; cond = '0;
    @(negedge clk);
    chk({tag, ".rst_ready"}, 32'(op_ready), 32'd0);
    chk({tag, ".rst_valid"}, 32'(mask_valid), 32'd0);
    chk({tag, ".rst_push"}, 32'(ps_push), 32'd0);
    chk({tag, ".rst_pop"}, 32'(ps_pop), 32'd0);
    chk({tag, ".rst_depth"}, 32'(depth), 32'd0);
    chk({tag, ".rst_err"}, 32'({err_overflow, err_underflow, none_taken}), 32'd0);
    reset = 1'b0;
    #1;
    chk({tag, ".init_push"}, 32'(ps_push), 32'd1);
    chk({tag, ".init_d"}, 32'(ps_d), 32'(ce));
    chk({tag, ".init_ready"}, 32'(op_ready), 32'd0);
    @(negedge clk);
    ms = {ce}; m_ovf = 0; m_unf = 0; m_nt = 0;
    check_idle(tag);
  endtask

  // Issue one op from IDLE (called on a falling edge) and check the result.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] c, input string tag);
    logic [N-1:0] top, t, p;
    int d;
    bit e_push, e_pop;
    logic [N-1:0] e_d;
    top = ms[$]; d = ms.size() - 1;
    e_push = 0; e_pop = 0; e_d = '0;
    op_valid = 1'b1; op = o; cond = c;
    #1;
    case (o)
      IF:        if (d != 6) begin e_push = 1; e_d = top & c; end
      ELS, ENDIF: if (d != 0) e_pop = 1;
      default: ;
    endcase
    chk({tag, ".push"}, 32'(ps_push), 32'(e_push));
    chk({tag, ".pop"}, 32'(ps_pop), 32'(e_pop));
    if (e_push) chk({tag, ".d"}, 32'(ps_d), 32'(e_d));
    @(negedge clk);
    op_valid = 1'b0; op = NOP;
    m_nt = 0;
    case (o)
      IF: if (d == 6) m_ovf = 1;
          else begin ms.push_back(top & c); m_nt = ((top & c) == '0); end
      ELS: if (d == 0) m_unf = 1;
           else begin
             t = top;
             void'(ms.pop_back());
             p = ms[$];
             ms.push_back(p & ~t);
             // an op offered during the second cycle must not be taken
             op_valid = 1'b1; op = IF; cond = 4'($urandom);
             #1;
             chk({tag, ".ep_ready"}, 32'(op_ready), 32'd0);
             chk({tag, ".ep_valid"}, 32'(mask_valid), 32'd0);
             chk({tag, ".ep_push"}, 32'(ps_push), 32'd1);
             chk({tag, ".ep_pop"}, 32'(ps_pop), 32'd0);
             chk({tag, ".ep_d"}, 32'(ps_d), 32'(p & ~t));
             chk({tag, ".ep_nt"}, 32'(none_taken), 32'd0);
             @(negedge clk);
             op_valid = 1'b0; op = NOP;
           end
      ENDIF: if (d == 0) m_unf = 1; else void'(ms.pop_back());
      default: ;
    endcase
    check_idle(tag);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    m_nt = 0;
    chk({tag, ".idle_push"}, 32'(ps_push), 32'd0);
    chk({tag, ".idle_pop"}, 32'(ps_pop), 32'd0);
    check_idle(tag);
  endtask

  initial begin
    op_valid = 1'b0; op = NOP; cond = '0; core_en = '0; reset = 1'b1;
    ms = {4'b0000}; m_ovf = 0; m_unf = 0; m_nt = 0;

    do_reset(4'b1111, "reset");

    issue(IF, 4'b0101, "if1");
    issue(ELS, 4'b0000, "else1");
    chk("else1.mask_val", 32'(active_mask), 32'b1010);
    issue(ENDIF, 4'b0000, "endif1");
    chk("endif1.mask_val", 32'(active_mask), 32'b1111);

    issue(IF, 4'b0011, "n.if_a");
    issue(IF, 4'b0110, "n.if_b");
    chk("n.if_b.mask_val", 32'(active_mask), 32'b0010);
    issue(ELS, 4'b0000, "n.else");
    chk("n.else.mask_val", 32'(active_mask), 32'b0001);
    issue(ENDIF, 4'b0000, "n.endif_b");
    chk("n.endif_b.mask_val", 32'(active_mask), 32'b0011);
    issue(ENDIF, 4'b0000, "n.endif_a");
    chk("n.endif_a.mask_val", 32'(active_mask), 32'b1111);

    issue(IF, 4'b0000, "zero.if");
    chk("zero.nt_pulse", 32'(none_taken), 32'd1);
    idle_cycle("zero.after");
    issue(ENDIF, 4'b0000, "zero.endif");

    for (int i = 0; i < 6; i++) issue(IF, 4'b1111, "ovf.fill");
    chk("ovf.depth6", 32'(depth), 32'd6);
    issue(IF, 4'b1111, "ovf.seventh");
    chk("ovf.flag", 32'(err_overflow), 32'd1);
    issue(NOP, 4'b1111, "ovf.nop");
    for (int i = 0; i < 6; i++) issue(ENDIF, 4'b0000, "ovf.drain");

    issue(ENDIF, 4'b0000, "unf.endif");
    chk("unf.flag", 32'(err_underflow), 32'd1);
    issue(ELS, 4'b0000, "unf.else");

    // Reset while the ELSE second cycle is in progress.
    issue(IF, 4'b1100, "mid.if");
    op_valid = 1'b1; op = ELS;
    @(negedge clk);
    op_valid = 1'b0; op = NOP;
    chk("mid.in_else_push", 32'(op_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid.rst_push", 32'(ps_push), 32'd0);
    do_reset(4'b1011, "mid.reset");

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 49);
      if (r == 0)       do_reset(4'($urandom), "rnd.reset");
      else if (r < 20)  issue(IF, 4'($urandom), "rnd.if");
      else if (r < 30)  issue(ELS, 4'($urandom), "rnd.else");
      else if (r < 42)  issue(ENDIF, 4'($urandom), "rnd.endif");
      else if (r < 46)  issue(NOP, 4'($urandom), "rnd.nop");
      else              idle_cycle("rnd.idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
